// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter sharing one data-RAM port among NUM_REQ valid/done requesters.
// Latency: grant one edge after req_valid; req_done one edge after ram_done; 3 cycles + RAM latency per txn.
// Backpressure: requesters hold req_valid until req_done; rdy=0 freezes every register and output.
module gelato_ram_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rdy,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          ram_valid,
    output logic                          ram_write,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic                          ram_done,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic [IDX_WIDTH-1:0]          grant_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH+1)'(NUM_REQ);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);

    state_t                  state_q,     state_d;
    logic [IDX_WIDTH-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [IDX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
    logic                    ram_valid_q, ram_valid_d;
    logic                    ram_write_q, ram_write_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic [NUM_REQ-1:0]      req_done_q,  req_done_d;
    logic [DATA_WIDTH-1:0]   req_rdata_q, req_rdata_d;

    logic                    srch_found;
    logic [IDX_WIDTH-1:0]    srch_idx;
    logic [IDX_WIDTH:0]      srch_cand;

    // Rotating priority search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        srch_found = 1'b0;
        srch_idx   = rr_ptr_q;
        srch_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            srch_cand = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(k);
            if (srch_cand >= NUM_REQ_W) begin
                srch_cand = srch_cand - NUM_REQ_W;
            end
            if (!srch_found && req_valid[srch_cand[IDX_WIDTH-1:0]]) begin
                srch_found = 1'b1;
                srch_idx   = srch_cand[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        ram_valid_d = ram_valid_q;
        ram_write_d = ram_write_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        req_done_d  = req_done_q;
        req_rdata_d = req_rdata_q;

        case (state_q)
            IDLE: begin
                if (srch_found) begin
                    grant_idx_d = srch_idx;
                    ram_valid_d = 1'b1;
                    ram_write_d = req_write[srch_idx];
                    ram_addr_d  = req_addr[srch_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_wdata_d = req_wdata[srch_idx*DATA_WIDTH +: DATA_WIDTH];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (ram_done) begin
                    ram_valid_d             = 1'b0;
                    req_done_d              = '0;
                    req_done_d[grant_idx_q] = 1'b1;
                    if (!ram_write_q) begin
                        req_rdata_d = ram_rdata;
                    end
                    // Winner drops to lowest priority for the next round.
                    rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                req_done_d = '0;
                state_d    = IDLE;
            end
            default: begin
                ram_valid_d = 1'b0;
                req_done_d  = '0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            ram_valid_q <= 1'b0;
            ram_write_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            req_done_q  <= '0;
            req_rdata_q <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            ram_valid_q <= ram_valid_d;
            ram_write_q <= ram_write_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            req_done_q  <= req_done_d;
            req_rdata_q <= req_rdata_d;
        end
    end

    assign req_done  = req_done_q;
    assign req_rdata = req_rdata_q;
    assign ram_valid = ram_valid_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign grant_idx = grant_idx_q;

    a_done_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_done_q));
    a_valid_busy:   assert property (@(posedge clk) disable iff (!rst_n) ram_valid_q == (state_q == BUSY));

endmodule
